// File: rtl/rv32i_types_pkg.sv
// Shared types for the issue-stage hazard logic: functional-unit indices and hazard FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rv32i_types_pkg;

  // Functional-unit index as carried on issue_fu and fu_done bit positions.
  typedef enum logic [1:0] {
    ALU_S       = 2'd0,
    MUL_S       = 2'd1,
    DIV_S       = 2'd2,
    LOADSTORE_S = 2'd3
  } fu_e;

  // RUN issues normally; DRAIN blocks issue after a serializing op until the machine is quiet.
  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } hz_state_e;

endpackage

// File: rtl/ooo_scoreboard_hazard_unit_if.sv
// Issue/writeback/control bundle between the decode pipeline and the scoreboard hazard unit.
// Latency: n/a (wiring only); outputs are combinational from the unit.
// Backpressure: issue_fire/stall_fetch_decode/pc_en carry the unit's backpressure to the front end.
interface ooo_scoreboard_hazard_unit_if #(
  parameter int NUM_REGS = 32,
  parameter int NUM_FU   = 4,
  parameter int NUM_WB   = 2,
  parameter int TAG_W    = 4
);
  localparam int REG_W = $clog2(NUM_REGS);
  localparam int FU_W  = $clog2(NUM_FU);

  // Issue request
  logic                         issue_valid;
  logic [FU_W-1:0]              issue_fu;
  logic [REG_W-1:0]             rs1;
  logic [REG_W-1:0]             rs2;
  logic [REG_W-1:0]             rd;
  logic                         rs1_used;
  logic                         rs2_used;
  logic                         rd_wen;
  logic [TAG_W-1:0]             issue_tag;

  // Pipeline control
  logic                         serialize;
  logic                         rob_full;
  logic                         rob_empty;
  logic                         mispredict;
  logic                         insert_priv_pc;
  logic                         i_mem_busy;

  // Writeback and unit completion
  logic [NUM_WB-1:0]            wb_valid;
  logic [NUM_WB-1:0][REG_W-1:0] wb_rd;
  logic [NUM_WB-1:0][TAG_W-1:0] wb_tag;
  logic [NUM_FU-1:0]            fu_done;

  // Results
  logic                         issue_fire;
  logic                         hazard;
  logic                         stall_fetch_decode;
  logic                         pc_en;
  logic                         fetch_decode_flush;
  logic                         decode_execute_flush;
  logic                         drain_busy;

  modport master (
    output issue_valid, issue_fu, rs1, rs2, rd, rs1_used, rs2_used, rd_wen, issue_tag,
    output serialize, rob_full, rob_empty, mispredict, insert_priv_pc, i_mem_busy,
    output wb_valid, wb_rd, wb_tag, fu_done,
    input  issue_fire, hazard, stall_fetch_decode, pc_en,
    input  fetch_decode_flush, decode_execute_flush, drain_busy
  );

  modport slave (
    input  issue_valid, issue_fu, rs1, rs2, rd, rs1_used, rs2_used, rd_wen, issue_tag,
    input  serialize, rob_full, rob_empty, mispredict, insert_priv_pc, i_mem_busy,
    input  wb_valid, wb_rd, wb_tag, fu_done,
    output issue_fire, hazard, stall_fetch_decode, pc_en,
    output fetch_decode_flush, decode_execute_flush, drain_busy
  );

endinterface

// File: rtl/ooo_reg_scoreboard.sv
// Per-register busy bit plus owning tag; set on issue, cleared by tag-matched writeback or flush.
// Latency: updates visible 1 cycle after the edge; lookups are combinational.
// Backpressure: none; caller gates set_en with its own issue handshake.
module ooo_reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int NUM_WB   = 2,
  parameter int TAG_W    = 4,
  localparam int REG_W   = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         set_en,
  input  logic [REG_W-1:0]             set_rd,
  input  logic [TAG_W-1:0]             set_tag,
  input  logic [NUM_WB-1:0]            clr_vld,
  input  logic [NUM_WB-1:0][REG_W-1:0] clr_rd,
  input  logic [NUM_WB-1:0][TAG_W-1:0] clr_tag,
  input  logic                         flush,
  input  logic [REG_W-1:0]             rs1,
  input  logic [REG_W-1:0]             rs2,
  input  logic [REG_W-1:0]             rd,
  output logic                         rs1_busy,
  output logic                         rs2_busy,
  output logic                         rd_busy
);

  logic [NUM_REGS-1:0]            busy;
  logic [NUM_REGS-1:0][TAG_W-1:0] tag;

  // Busy/tag update: reset > flush > (writeback clear, then issue set so the set wins on collision).
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      tag  <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      for (int k = 0; k < NUM_WB; k++) begin
        // Only the current owner may release the register; older producers are stale.
        if (clr_vld[k] && busy[clr_rd[k]] && (tag[clr_rd[k]] == clr_tag[k])) begin
          busy[clr_rd[k]] <= 1'b0;
        end
      end
      // x0 is hardwired zero and never has a pending producer.
      if (set_en && (set_rd != '0)) begin
        busy[set_rd] <= 1'b1;
        tag[set_rd]  <= set_tag;
      end
    end
  end

  assign rs1_busy = busy[rs1];
  assign rs2_busy = busy[rs2];
  assign rd_busy  = busy[rd];

endmodule

// File: rtl/ooo_scoreboard_hazard_unit.sv
// Issue-stage hazard unit: RAW/WAW scoreboard, per-unit occupancy, serialize drain and flush control.
// Latency: hazard/stall/flush outputs combinational; scoreboard and counters update next cycle.
// Backpressure: holds issue (issue_fire=0, stall_fetch_decode=1) on hazard, full ROB or drain.
module ooo_scoreboard_hazard_unit
  import rv32i_types_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_FU   = 4,
  parameter int FU_DEPTH = 2,
  parameter int NUM_WB   = 2,
  parameter int TAG_W    = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  ooo_scoreboard_hazard_unit_if.slave io
);

  localparam int FU_W  = $clog2(NUM_FU);
  localparam int CNT_W = $clog2(FU_DEPTH + 1);

  hz_state_e                    state;
  logic                         drain_q;
  logic [NUM_FU-1:0][CNT_W-1:0] fu_count;

  logic rs1_busy, rs2_busy, rd_busy;
  logic data_hazard, struct_hazard, hazard, flush, fire, stall;
  logic serialize_block, counts_zero;

  ooo_reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WB   (NUM_WB),
    .TAG_W    (TAG_W)
  ) u_sb (
    .clk      (CLK),
    .rst      (RST),
    .set_en   (fire & io.rd_wen),
    .set_rd   (io.rd),
    .set_tag  (io.issue_tag),
    .clr_vld  (io.wb_valid),
    .clr_rd   (io.wb_rd),
    .clr_tag  (io.wb_tag),
    .flush    (flush),
    .rs1      (io.rs1),
    .rs2      (io.rs2),
    .rd       (io.rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

  // Issue decision and front-end control, all combinational from current state and inputs.
  always_comb begin
    flush           = io.mispredict | io.insert_priv_pc;
    data_hazard     = (io.rs1_used & rs1_busy) | (io.rs2_used & rs2_busy) | (io.rd_wen & rd_busy);
    struct_hazard   = (fu_count[io.issue_fu] == CNT_W'(FU_DEPTH));
    hazard          = io.issue_valid & (data_hazard | struct_hazard);
    // A serializing op may only leave decode once everything older has retired.
    serialize_block = io.serialize & ~io.rob_empty;
    fire            = io.issue_valid & ~hazard & ~io.rob_full & ~flush &
                      (state == RUN) & ~serialize_block;
    stall           = io.issue_valid & ~fire & ~flush;
    counts_zero     = (fu_count == '0);
  end

  assign io.issue_fire           = fire;
  assign io.hazard               = hazard;
  assign io.stall_fetch_decode   = stall;
  assign io.pc_en                = ~(io.i_mem_busy | stall);
  assign io.fetch_decode_flush   = flush;
  assign io.decode_execute_flush = flush;
  assign io.drain_busy           = drain_q;

  // Per-unit occupancy: +1 on issue, -1 on completion, net zero when both; completion at 0 ignored.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      fu_count <= '0;
    end else begin
      for (int f = 0; f < NUM_FU; f++) begin
        if ((fire && (io.issue_fu == FU_W'(f))) && !(io.fu_done[f] && (fu_count[f] != '0))) begin
          fu_count[f] <= fu_count[f] + 1'b1;
        end else if (!(fire && (io.issue_fu == FU_W'(f))) && io.fu_done[f] && (fu_count[f] != '0)) begin
          fu_count[f] <= fu_count[f] - 1'b1;
        end
      end
    end
  end

  // Drain FSM with registered drain_busy; a flush abandons the drain since the ops are discarded.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= RUN;
      drain_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (fire && io.serialize) begin
            state   <= DRAIN;
            drain_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (flush || (io.rob_empty && counts_zero)) begin
            state   <= RUN;
            drain_q <= 1'b0;
          end
        end
        default: begin
          state   <= RUN;
          drain_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
